// File: rtl/pgcntr_pkg.sv
// Purpose : shared constants, seek FSM states and slot decode for the absolute page counter.
// Latency : n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: page-counter arithmetic constants, frame-slot positions,
// the seek state enum and the rotator-to-slot-index decoder.
package pgcntr_pkg;

    // Page counter arithmetic: mod-1531 counter, +522 per frame, 12-bit serial word.
    localparam int PG_MOD  = 1531;
    localparam int PG_STEP = 522;
    localparam int PG_BITS = 12;

    localparam logic [PG_BITS-1:0] PG_MOD_V = PG_BITS'(PG_MOD);

    // Frame slot positions within the 20-slot rotator.
    localparam int N_SLOTS   = 20;
    localparam int SLOT_W    = 5;
    localparam int SLOT_LSB0 = 0;
    localparam int SLOT_MSB  = 11;
    localparam int SLOT_EVAL = 12;
    localparam int SLOT_LAST = 19;

    // Width of the RUN frame counter (saturates at 2047).
    localparam int FCNT_W = 11;

    typedef logic [SLOT_W-1:0] slot_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        RUN   = 3'd2,
        DONE  = 3'd3,
        ERR   = 3'd4
    } seek_state_e;

    // Active-low one-hot rotator to slot index. Returns all-ones (31) when
    // no slot is active so that it never aliases a real slot.
    function automatic slot_t slot_decode(input logic [N_SLOTS-1:0] rot_n);
        slot_t idx;
        idx = '1;
        for (int i = 0; i < N_SLOTS; i++) begin
            if (!rot_n[i]) begin
                idx = slot_t'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/mdl_pgseek_sercmp.sv
// Purpose : serial LSB-first comparator of the page-counter write-back against the seek target.
// Latency : mismatch flag settles one enable cycle after slot 11; hit strobe is combinational in slot 12.
// Backpressure: none; advances only on enabled clock cycles.
//
// Ports:
//   i_MCLK, i_RST   clock and synchronous active-high reset
//   i_en            clock enable (active-high, already decoded)
//   i_slot          current frame slot index
//   i_lsb           serial write-back bit, valid in slots 0..11
//   i_target        target page word
//   o_mismatch      accumulated mismatch flag for the current frame
//   o_hit           high during slot 12 when all 12 bits matched
module mdl_pgseek_sercmp
    import pgcntr_pkg::*;
(
    input  logic               i_MCLK,
    input  logic               i_RST,
    input  logic               i_en,
    input  slot_t              i_slot,
    input  logic               i_lsb,
    input  logic [PG_BITS-1:0] i_target,
    output logic               o_mismatch,
    output logic               o_hit
);

    logic mis_q;
    logic mis_d;
    logic bit_diff;
    logic in_word;

    always_comb begin
        in_word  = (i_slot <= slot_t'(SLOT_MSB));
        bit_diff = 1'b0;
        if (in_word) begin
            bit_diff = i_lsb ^ i_target[i_slot[3:0]];
        end

        mis_d = mis_q;
        if (i_en) begin
            // Slot 0 starts a fresh frame: the flag restarts from the first bit.
            if (i_slot == slot_t'(SLOT_LSB0)) begin
                mis_d = bit_diff;
            end else if (in_word) begin
                mis_d = mis_q | bit_diff;
            end
        end
    end

    // Reset to "mismatch" so a stray slot-12 after reset never reads as a hit.
    always_ff @(posedge i_MCLK) begin
        if (i_RST) begin
            mis_q <= 1'b1;
        end else begin
            mis_q <= mis_d;
        end
    end

    assign o_mismatch = mis_q;
    assign o_hit      = (i_slot == slot_t'(SLOT_EVAL)) & ~mis_q;

endmodule

// File: rtl/mdl_pgseek_ctrl.sv
// Purpose : seek sequencer; clears the absolute page counter, runs it, and stops it on the target page.
// Latency : accept at slot 19, one CLEAR frame, then n RUN frames; DONE/ERR visible one enable cycle after slot 12.
// Backpressure: level req/ack; REQ held until DONE/ERR, dropping REQ early aborts the seek.
//
// Ports:
//   i_MCLK, i_RST          master clock, synchronous active-high reset
//   i_CLK2M_PCEN_n         active-low clock enable; all state advances only when low
//   i_ROT20_n              active-low one-hot frame slot rotator (slots 0..19)
//   i_SEEK_REQ/PAGE        seek request level and 12-bit target page
//   i_ABSPGCNTR_LSB        counter write-back bit, LSB first in slots 0..11
//   o_ABSPGCNTR_CNT_START  one-enable-cycle pulse enabling the constant add
//   o_ABSPGCNTR_CNT_STOP   level disabling the constant add
//   o_ALD_nB_U             low forces the counter write-back to zero
//   o_SEEK_BUSY/DONE/ERR   seek status
//   o_FRAME_CNT            RUN frames elapsed in the current seek (saturating)
module mdl_pgseek_ctrl
    import pgcntr_pkg::*;
#(
    parameter int unsigned P_MAX_FRAMES = 1531
)
(
    input  logic               i_MCLK,
    input  logic               i_RST,
    input  logic               i_CLK2M_PCEN_n,
    input  logic [19:0]        i_ROT20_n,
    input  logic               i_SEEK_REQ,
    input  logic [11:0]        i_SEEK_PAGE,
    input  logic               i_ABSPGCNTR_LSB,
    output logic               o_ABSPGCNTR_CNT_START,
    output logic               o_ABSPGCNTR_CNT_STOP,
    output logic               o_ALD_nB_U,
    output logic               o_SEEK_BUSY,
    output logic               o_SEEK_DONE,
    output logic               o_SEEK_ERR,
    output logic [10:0]        o_FRAME_CNT
);

    logic  en;
    slot_t slot;

    seek_state_e        state_q, state_d;
    logic [PG_BITS-1:0] target_q, target_d;
    logic               start_q, start_d;
    logic               stop_q, stop_d;
    logic               ald_q, ald_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [FCNT_W-1:0]  frame_cnt_q, frame_cnt_d;
    logic [FCNT_W-1:0]  frame_inc;

    logic cmp_mismatch;
    logic cmp_hit;

    assign en   = ~i_CLK2M_PCEN_n;
    assign slot = slot_decode(i_ROT20_n);

    mdl_pgseek_sercmp u_sercmp (
        .i_MCLK     (i_MCLK),
        .i_RST      (i_RST),
        .i_en       (en),
        .i_slot     (slot),
        .i_lsb      (i_ABSPGCNTR_LSB),
        .i_target   (target_q),
        .o_mismatch (cmp_mismatch),
        .o_hit      (cmp_hit)
    );

    always_comb begin
        state_d     = state_q;
        target_d    = target_q;
        start_d     = start_q;
        stop_d      = stop_q;
        ald_d       = ald_q;
        busy_d      = busy_q;
        done_d      = done_q;
        err_d       = err_q;
        frame_cnt_d = frame_cnt_q;

        frame_inc = (frame_cnt_q == '1) ? frame_cnt_q : frame_cnt_q + 1'b1;

        if (en) begin
            // START is a single enable-cycle pulse; it only survives if re-armed below.
            start_d = 1'b0;

            unique case (state_q)
                IDLE: begin
                    if (slot == slot_t'(SLOT_LAST) && i_SEEK_REQ) begin
                        target_d    = i_SEEK_PAGE;
                        frame_cnt_d = '0;
                        if (i_SEEK_PAGE >= PG_MOD_V) begin
                            err_d   = 1'b1;
                            state_d = ERR;
                        end else begin
                            busy_d  = 1'b1;
                            ald_d   = 1'b0;
                            state_d = CLEAR;
                        end
                    end
                end

                CLEAR: begin
                    if (!i_SEEK_REQ) begin
                        start_d = 1'b0;
                        stop_d  = 1'b1;
                        ald_d   = 1'b1;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end else if (slot == slot_t'(SLOT_LAST - 1) && target_q != '0) begin
                        // Registered outputs: arm START/drop STOP one slot early so
                        // the pulse lands exactly on the last CLEAR slot, while the
                        // write-back is still forced to zero. The first add then
                        // produces 522 for RUN frame 1.
                        start_d = 1'b1;
                        stop_d  = 1'b0;
                    end else if (slot == slot_t'(SLOT_LAST)) begin
                        ald_d = 1'b1;
                        if (target_q == '0) begin
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                            state_d = DONE;
                        end else begin
                            state_d = RUN;
                        end
                    end
                end

                RUN: begin
                    if (!i_SEEK_REQ) begin
                        stop_d  = 1'b1;
                        ald_d   = 1'b1;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end else if (cmp_hit) begin
                        // STOP rises in slot 13, well before the next frame's add.
                        frame_cnt_d = frame_inc;
                        stop_d      = 1'b1;
                        done_d      = 1'b1;
                        busy_d      = 1'b0;
                        state_d     = DONE;
                    end else if (slot == slot_t'(SLOT_EVAL) && cmp_mismatch) begin
                        frame_cnt_d = frame_inc;
                        if (32'(frame_inc) >= P_MAX_FRAMES) begin
                            stop_d  = 1'b1;
                            err_d   = 1'b1;
                            busy_d  = 1'b0;
                            state_d = ERR;
                        end
                    end
                end

                DONE, ERR: begin
                    busy_d = 1'b0;
                    stop_d = 1'b1;
                    if (!i_SEEK_REQ) begin
                        done_d  = 1'b0;
                        err_d   = 1'b0;
                        state_d = IDLE;
                    end
                end

                default: begin
                    state_d = IDLE;
                    stop_d  = 1'b1;
                    ald_d   = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge i_MCLK) begin
        if (i_RST) begin
            state_q     <= IDLE;
            target_q    <= '0;
            start_q     <= 1'b0;
            stop_q      <= 1'b1;
            ald_q       <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            target_q    <= target_d;
            start_q     <= start_d;
            stop_q      <= stop_d;
            ald_q       <= ald_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign o_ABSPGCNTR_CNT_START = start_q;
    assign o_ABSPGCNTR_CNT_STOP  = stop_q;
    assign o_ALD_nB_U            = ald_q;
    assign o_SEEK_BUSY           = busy_q;
    assign o_SEEK_DONE           = done_q;
    assign o_SEEK_ERR            = err_q;
    assign o_FRAME_CNT           = frame_cnt_q;

endmodule
